// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin request arbiter: FSM state
// encodings and default sizing.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } arb_state_t;

  localparam int ARB_N_DEFAULT        = 4;
  localparam int ARB_MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: returns the first asserted request
// found scanning upward from ptr and wrapping modulo N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = ARB_N_DEFAULT,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  localparam logic [IDW:0] N_W = (IDW+1)'(N);

  // rot_idx[k] is the requester examined at scan position k; rot[k] its request
  logic [IDW-1:0] rot_idx [N];
  logic [N-1:0]   rot;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [IDW:0] sum;
      // one extra bit so ptr+gi cannot overflow before the modulo-N wrap
      assign sum         = {1'b0, ptr} + (IDW+1)'(gi);
      assign rot_idx[gi] = (sum >= N_W) ? IDW'(sum - N_W) : sum[IDW-1:0];
      assign rot[gi]     = req[rot_idx[gi]];
    end
  endgenerate

  // lowest scan position with a request wins; scanning downward lets it overwrite
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) idx = rot_idx[k];
    end
  end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter: grants one requester at a time, holds while its level
// request stays high (at most MAX_HOLD cycles), then inserts one dead cycle
// before the next arbitration. The priority pointer moves past each released
// owner, so a timed-out owner re-enters as lowest priority.
module rr_req_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEFAULT,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
  parameter int IDW      = 2,
  parameter int CW       = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  arb_state_t     state_reg;
  logic [N-1:0]   gnt_reg;
  logic [IDW-1:0] gnt_id_reg;
  logic           busy_reg;
  logic           timeout_reg;
  logic [IDW-1:0] ptr_reg;
  logic [CW-1:0]  hold_cnt_reg;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_onehot;
  logic           owner_req;
  logic           hold_ok;
  logic [IDW-1:0] ptr_next;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req (req),
    .ptr (ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;
  assign owner_req   = req[gnt_id_reg];
  assign hold_ok     = hold_cnt_reg < CW'(MAX_HOLD);
  assign ptr_next    = (gnt_id_reg == IDW'(N - 1)) ? '0 : gnt_id_reg + IDW'(1);

  // FSM with registered outputs: arbitrate in IDLE, count hold in GRANT,
  // one dead cycle in RELEASE; timeout defaults low so it pulses for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= '0;
      gnt_id_reg   <= '0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_reg      <= pick_onehot;
            gnt_id_reg   <= pick_idx;
            busy_reg     <= 1'b1;
            hold_cnt_reg <= CW'(1);
            state_reg    <= ST_GRANT;
          end else begin
            gnt_reg      <= '0;
            gnt_id_reg   <= '0;
            busy_reg     <= 1'b0;
            hold_cnt_reg <= '0;
          end
        end
        ST_GRANT: begin
          if (owner_req && hold_ok) begin
            hold_cnt_reg <= hold_cnt_reg + CW'(1);
          end else begin
            // a still-high request here means the hold limit forced this release
            timeout_reg  <= owner_req;
            gnt_reg      <= '0;
            gnt_id_reg   <= '0;
            busy_reg     <= 1'b0;
            hold_cnt_reg <= '0;
            ptr_reg      <= ptr_next;
            state_reg    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg    <= ST_IDLE;
          gnt_reg      <= '0;
          gnt_id_reg   <= '0;
          busy_reg     <= 1'b0;
          hold_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_id  = gnt_id_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: directed stimulus pushes expected grant episodes
// (owner, length, timeout, gap) into a queue; a negedge monitor rebuilds
// episodes from the DUT outputs, pops and compares, and checks per-cycle rules.
module tb_rr_req_arbiter;

  localparam int N  = 4;
  localparam int MH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  rr_req_arbiter #(
    .N        (N),
    .MAX_HOLD (MH),
    .IDW      (2),
    .CW       (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int len;
    bit to;
    int gap;   // 0: gap not checked
  } ep_t;

  ep_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  // monitor state
  bit  prev_busy = 1'b0;
  int  cur_id    = 0;
  int  cur_len   = 0;
  int  cur_gap   = 0;
  int  gap_cnt   = 0;
  int  ep_num    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic push(input int id, input int len, input bit to, input int gap);
    ep_t e;
    e.id  = id;
    e.len = len;
    e.to  = to;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // one full ownership: request pattern full, owner id holds len cycles,
  // drops its bit for the release edge, then the dead cycle back to IDLE
  task automatic grant_cycle(input logic [3:0] full, input int id, input int len, input int gap);
    logic [3:0] own;
    own = 4'b0001 << id;
    push(id, len, 1'b0, gap);
    req = full;
    tick();
    repeat (len - 1) tick();
    req = full & ~own;
    tick();
    tick();
  endtask

  // monitor: per-cycle rules plus episode reconstruction and scoreboard pop
  always @(negedge clk) begin
    if (mon_en && rst !== 1'b1) begin
      checks++;
      if (!$onehot0(gnt) || $isunknown(gnt)) begin
        errors++;
        $display("FAIL onehot0: gnt=%b", gnt);
      end
      checks++;
      if (busy !== (|gnt)) begin
        errors++;
        $display("FAIL busy_eq_or_gnt: busy=%b gnt=%b", busy, gnt);
      end
      checks++;
      if (timeout === 1'b1 && !(prev_busy && busy === 1'b0)) begin
        errors++;
        $display("FAIL timeout_placement: timeout=1 prev_busy=%0d busy=%b", prev_busy, busy);
      end
      checks++;
      if (busy !== 1'b1 && gnt_id !== 2'd0) begin
        errors++;
        $display("FAIL gnt_id_idle: gnt_id=%0d required 0", gnt_id);
      end
    end
    if (mon_en) begin
      if (busy === 1'b1) begin
        if (!prev_busy) begin
          cur_id  = int'(gnt_id);
          cur_len = 1;
          cur_gap = gap_cnt;
        end else begin
          cur_len++;
        end
        checks++;
        if (int'(gnt_id) != cur_id || gnt !== (4'b0001 << gnt_id)) begin
          errors++;
          $display("FAIL owner_stable: gnt=%b gnt_id=%0d episode owner %0d", gnt, gnt_id, cur_id);
        end
        gap_cnt = 0;
      end else begin
        if (prev_busy) begin
          ep_num++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant: owner %0d len %0d with nothing expected", cur_id, cur_len);
          end else begin
            ep_t e;
            e = exp_q.pop_front();
            if (cur_id != e.id) begin
              errors++;
              $display("FAIL ep%0d_owner: got %0d expected %0d", ep_num, cur_id, e.id);
            end
            checks++;
            if (cur_len != e.len) begin
              errors++;
              $display("FAIL ep%0d_len: got %0d expected %0d", ep_num, cur_len, e.len);
            end
            checks++;
            if (timeout !== e.to) begin
              errors++;
              $display("FAIL ep%0d_timeout: got %b expected %0d", ep_num, timeout, e.to);
            end
            if (e.gap != 0) begin
              checks++;
              if (cur_gap != e.gap) begin
                errors++;
                $display("FAIL ep%0d_gap: got %0d expected %0d", ep_num, cur_gap, e.gap);
              end
            end
            $display("episode %0d: owner=%0d len=%0d timeout=%b gap=%0d", ep_num, cur_id, cur_len, timeout, cur_gap);
          end
        end
        gap_cnt++;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin
    int rr_ids[5];
    rr_ids = '{0, 1, 2, 3, 0};

    // 1. reset with all requests high, then single request from ptr 0
    rst = 1'b1;
    req = 4'b1111;
    tick();
    mon_en = 1'b1;
    tick();
    check("reset_gnt", int'(gnt), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_gnt_id", int'(gnt_id), 0);
    rst = 1'b0;
    req = 4'b0100;
    push(2, 3, 1'b0, 0);
    tick();
    check("first_grant_latency_gnt", int'(gnt), 4);
    tick();
    tick();
    req = 4'b0000;
    tick();
    tick();

    // 2. round robin from ptr 0 with all requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      grant_cycle(4'b1111, rr_ids[k], 3, (k == 0) ? 0 : 2);
    end

    // 3. timeout: requester 1 holds forever (ptr now 1)
    push(1, MH, 1'b1, 0);
    req = 4'b0010;
    tick();
    repeat (MH) tick();
    check("timeout_pulse", int'(timeout), 1);
    tick();
    check("timeout_one_cycle", int'(timeout), 0);

    // 4. re-grant to 1 after the dead cycle, drop coincident with hold limit
    grant_cycle(4'b0010, 1, MH, 2);

    // 5. wrap and skip: grant 2 moves ptr to 3, then 0101 -> 0, then 2
    grant_cycle(4'b0100, 2, 2, 0);
    grant_cycle(4'b0101, 0, 2, 2);
    grant_cycle(4'b0101, 2, 2, 2);

    // 6. mid-grant reset of owner 2, pointer must return to 0
    push(2, 3, 1'b0, 2);
    req = 4'b0100;
    tick();
    tick();
    tick();
    rst = 1'b1;
    req = 4'b1100;
    tick();
    check("midreset_gnt", int'(gnt), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_gnt_id", int'(gnt_id), 0);
    rst = 1'b0;
    push(2, 2, 1'b0, 0);
    tick();
    check("post_reset_winner_gnt", int'(gnt), 4);
    check("post_reset_winner_id", int'(gnt_id), 2);
    tick();
    req = 4'b0000;
    tick();
    tick();
    repeat (4) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
